// File: rtl/fifo_rd_arbiter_pkg.sv
// fifo_rd_arbiter_pkg: reader index type (bounded by FIFO_RD_ARB_MAX_N) and modulo-N index add shared by fifo_rd_arbiter and rr_burst_arbiter
package fifo_rd_arbiter_pkg;
  localparam int FIFO_RD_ARB_MAX_N = 8;
  localparam int IDX_W = $clog2(FIFO_RD_ARB_MAX_N);
  typedef logic [IDX_W-1:0] rd_idx_t;
  function automatic rd_idx_t idx_add(input rd_idx_t a, input rd_idx_t b, input logic [IDX_W:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= n) ? rd_idx_t'(s - n) : rd_idx_t'(s);
  endfunction
endpackage

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter with bounded bursts; in clk, reset, req[N], fifo_empty; out accept (FIFO pop), grant[N] one-hot, win index
module rr_burst_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         fifo_empty,
  output logic         accept,
  output logic [N-1:0] grant,
  output rd_idx_t      win
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BL = CW'(BURST);
  localparam logic [IDX_W:0] NL = (IDX_W + 1)'(N);
  localparam logic [N-1:0] ONE = N'(1);
  rd_idx_t ptr, owner, off;
  logic own_vld, own_req, keep, drop;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? rd_idx_t'(k) : off;
    own_req = own_vld & |(req & (ONE << owner));
    keep = own_req & (cnt < BL);
    drop = own_vld & ~own_req;
    win = keep ? owner : idx_add(ptr, off, NL);
    accept = |req & ~fifo_empty & ~reset;
    grant = accept ? ONE << win : '0;
    cnt_n = keep ? cnt + 1'b1 : CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= '0;
      owner <= '0;
      own_vld <= 1'b0;
      cnt <= '0;
    end else if (accept && cnt_n == BL) begin
      ptr <= idx_add(win, rd_idx_t'(1), NL);
      own_vld <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      ptr <= drop ? idx_add(win, rd_idx_t'(1), NL) : ptr;
      owner <= win;
      own_vld <= 1'b1;
      cnt <= cnt_n;
    end else if (drop) begin
      ptr <= idx_add(owner, rd_idx_t'(1), NL);
      own_vld <= 1'b0;
      cnt <= '0;
    end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares one FIFO read port among N readers, steering fifo_q back via a RDLATENCY tag pipeline; ports clk, reset, fifo_empty/fifo_rdreq/fifo_q, req/grant/rdvalid[N], rdata, busy; FIFO_RD_ARBITER_OUTREG_EN registers rdata/rdvalid (+1 latency)
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int N         = 2,
  parameter int WIDTH     = 64,
  parameter int RDLATENCY = 1,
  parameter int BURST     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     rdvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);
  localparam logic [N-1:0] ONE = N'(1);
  rd_idx_t win;
  logic [RDLATENCY-1:0] sv;
  rd_idx_t si [RDLATENCY];
  logic [N-1:0] last_oh;
  rr_burst_arbiter #(.N(N), .BURST(BURST)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .fifo_empty(fifo_empty),
    .accept(fifo_rdreq),
    .grant(grant),
    .win(win)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sv <= '0;
      si <= '{default: '0};
    end else begin
      sv[0] <= fifo_rdreq;
      si[0] <= win;
      for (int i = 1; i < RDLATENCY; i++) begin
        sv[i] <= sv[i-1];
        si[i] <= si[i-1];
      end
    end
  assign last_oh = sv[RDLATENCY-1] ? ONE << si[RDLATENCY-1] : '0;
`ifdef FIFO_RD_ARBITER_OUTREG_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata <= '0;
      rdvalid <= '0;
    end else begin
      rdata <= fifo_q;
      rdvalid <= last_oh;
    end
  assign busy = |sv | |rdvalid;
`else
  assign rdata = fifo_q;
  assign rdvalid = last_oh;
  assign busy = |sv;
`endif
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: randomized and directed checks of fifo_rd_arbiter against a queue-based reference model
module tb_fifo_rd_arbiter;
  localparam int N = 2, W = 64, RDL = 1, BURST = 4;
`ifdef FIFO_RD_ARBITER_OUTREG_EN
  localparam int OREG = 1;
`else
  localparam int OREG = 0;
`endif
  localparam int LAT = RDL + OREG;
  localparam int LB = 3 + OREG;
  localparam logic [N-1:0] ONE = N'(1);
  logic clk = 0, reset = 1, fifo_empty = 1, fifo_rdreq, busy;
  logic [W-1:0] fifo_q = '0, rdata;
  logic [N-1:0] req = '0, grant, rdvalid;
  logic reset_b = 1, fifo_empty_b = 0, fifo_rdreq_b, busy_b;
  logic [15:0] fifo_q_b = '0, rdata_b;
  logic [3:0] req_b = '0, grant_b, rdvalid_b;
  int checks = 0, errors = 0, cyc = 0;
  int m_ptr = 0, m_own = -1, m_cnt = 0;
  int hist [1024];
  logic [W-1:0] hdat [1024];
  logic [W-1:0] fq [$];
  logic [N-1:0] obs_grant;

  fifo_rd_arbiter #(.N(N), .WIDTH(W), .RDLATENCY(RDL), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
    .req(req), .grant(grant), .rdvalid(rdvalid), .rdata(rdata), .busy(busy));
  fifo_rd_arbiter #(.N(4), .WIDTH(16), .RDLATENCY(3), .BURST(1)) dut_b (
    .clk(clk), .reset(reset_b), .fifo_empty(fifo_empty_b), .fifo_rdreq(fifo_rdreq_b), .fifo_q(fifo_q_b),
    .req(req_b), .grant(grant_b), .rdvalid(rdvalid_b), .rdata(rdata_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one cycle of DUT A: drive at negedge, compare #1 later, then advance the model
  task automatic step(input logic [N-1:0] r, input bit fe);
    int win;
    bit acc, drop, eb;
    logic [N-1:0] ev;
    req = r;
    fifo_empty = fe || fq.size() == 0;
    fifo_q = (cyc >= RDL) ? hdat[cyc-RDL] : '0;
    if (reset) begin
      for (int i = 0; i < cyc; i++) hist[i] = -1;
      m_ptr = 0; m_own = -1; m_cnt = 0;
    end
    #1;
    acc = r != 0 && !fifo_empty && !reset;
    win = -1;
    if (m_own >= 0 && (r & (ONE << m_own)) != 0 && m_cnt < BURST) win = m_own;
    else for (int k = N - 1; k >= 0; k--) if ((r & (ONE << ((m_ptr + k) % N))) != 0) win = (m_ptr + k) % N;
    obs_grant = grant;
    chk("fifo_rdreq", 64'(fifo_rdreq), 64'(acc));
    chk("grant", 64'(grant), acc ? 64'(ONE << win) : 64'(0));
    ev = (cyc >= LAT && hist[cyc-LAT] >= 0) ? ONE << hist[cyc-LAT] : '0;
    chk("rdvalid", 64'(rdvalid), 64'(ev));
    if (ev != 0) chk("rdata", rdata, hdat[cyc-LAT]);
    eb = 0;
    for (int g = cyc - LAT; g < cyc; g++) if (g >= 0 && hist[g] >= 0) eb = 1;
    chk("busy", 64'(busy), 64'(eb));
    hist[cyc] = acc ? win : -1;
    hdat[cyc] = '0;
    if (acc) begin
      hdat[cyc] = fq.pop_front();
      drop = m_own >= 0 && (r & (ONE << m_own)) == 0;
      if (win == m_own) m_cnt++;
      else begin m_own = win; m_cnt = 1; end
      if (m_cnt == BURST) begin m_ptr = (win + 1) % N; m_own = -1; m_cnt = 0; end
      else if (drop) m_ptr = (win + 1) % N;
    end else if (m_own >= 0 && (r & (ONE << m_own)) == 0) begin
      m_ptr = (m_own + 1) % N; m_own = -1; m_cnt = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) hist[i] = -1;
    @(negedge clk);
    step(2'b00, 0);
    step(2'b11, 0);
    reset = 0;
    fq = '{64'hA, 64'hB, 64'hC};
    repeat (3) begin step(2'b01, 0); chk("single_grant", 64'(obs_grant), 64'(1)); end
    repeat (2) step(2'b01, 0);
    reset = 1; step(2'b00, 0); reset = 0;
    for (int i = 0; i < 8; i++) fq.push_back(64'h100 + 64'(i));
    for (int i = 0; i < 8; i++) begin step(2'b11, 0); chk("burst_seq", 64'(obs_grant), i < 4 ? 64'(1) : 64'(2)); end
    repeat (2) step(2'b00, 0);
    for (int i = 0; i < 4; i++) fq.push_back(64'h200 + 64'(i));
    repeat (5) begin step(2'b11, 1); chk("empty_nogrant", 64'(obs_grant), 64'(0)); end
    step(2'b11, 0);
    chk("empty_first", 64'(obs_grant), 64'(1));
    repeat (3) step(2'b11, 0);
    step(2'b00, 0);
    for (int i = 0; i < 4; i++) fq.push_back(64'h300 + 64'(i));
    repeat (2) step(2'b11, 0);
    reset = 1;
    step(2'b11, 0);
    step(2'b00, 0);
    reset = 0;
    repeat (3) step(2'b00, 0);
    fq.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0) fq.push_back({$urandom, $urandom});
      reset = $urandom_range(49) == 0;
      step(N'($urandom_range(3)), $urandom_range(7) == 0);
    end
    reset = 0;
    reset_b = 0;
    for (int c = 0; c < 14; c++) begin
      req_b = c < 8 ? 4'hf : 4'h0;
      fifo_q_b = 16'(32'h100 + c - 3);
      #1;
      chk("b_grant", 64'(grant_b), c < 8 ? 64'(1) << (c % 4) : 64'(0));
      chk("b_rdvalid", 64'(rdvalid_b), (c >= LB && c - LB < 8) ? 64'(1) << ((c - LB) % 4) : 64'(0));
      if (c >= LB && c - LB < 8) chk("b_rdata", 64'(rdata_b), 64'(16'(32'h100 + c - LB)));
      chk("b_busy", 64'(busy_b), 64'(c >= 1 && c <= 7 + LB));
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
